// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: select codes, op classes, FSM states.
package alu_op_sequencer_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_NEG = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSettle,
    StCapture,
    StWriteLo,
    StWriteHi,
    StDone
  } state_e;

  // Ops that produce both HI and LO results.
  function automatic logic is_two_result(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Anything outside the defined select set is rejected.
  function automatic logic is_illegal(input logic [3:0] op);
    return !(op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NEG, OP_NOT,
                        OP_SRA, OP_SHL, OP_SHR, OP_ROL, OP_ROR});
  endfunction

endpackage

// File: rtl/alu_op_sequencer_wb_handshake.sv
// Single-request write driver: raises wr_lo or wr_hi with data and holds it until acknowledged.
module alu_op_sequencer_wb_handshake #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             sel_hi_i,
  input  logic [Width-1:0] data_i,
  input  logic             ack_i,
  output logic             wr_lo_o,
  output logic             wr_hi_o,
  output logic [Width-1:0] wr_data_o,
  output logic             fire_o
);

  // Ack only counts while a request is outstanding.
  assign fire_o = (wr_lo_o | wr_hi_o) & ack_i;

  // Load wins over completion so a follow-on request can replace the acked one back to back.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_lo_o   <= 1'b0;
      wr_hi_o   <= 1'b0;
      wr_data_o <= '0;
    end else if (load_i) begin
      wr_lo_o   <= !sel_hi_i;
      wr_hi_o   <= sel_hi_i;
      wr_data_o <= data_i;
    end else if (fire_o) begin
      wr_lo_o <= 1'b0;
      wr_hi_o <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives one ALU operation end to end: accept, validate, settle, capture Z, write LO/HI back.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned WIDTH         = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         alu_select,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [2*WIDTH-1:0] alu_z,
  output logic               wr_lo,
  output logic               wr_hi,
  output logic [WIDTH-1:0]   wr_data,
  input  logic               wr_ack
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic             wr_fire;
  logic             hs_load;
  logic             hs_sel_hi;
  logic [WIDTH-1:0] hs_data;

  // LO goes straight from Z into the write-data register at capture; HI waits in hi_q.
  assign hs_load   = (state_q == StCapture) ||
                     ((state_q == StWriteLo) && wr_fire && is_two_result(alu_select));
  assign hs_sel_hi = (state_q == StWriteLo);
  assign hs_data   = (state_q == StCapture) ? alu_z[WIDTH-1:0] : hi_q;

  alu_op_sequencer_wb_handshake #(
    .Width(WIDTH)
  ) u_wb_handshake (
    .clk_i    (clock),
    .rst_ni   (clear),
    .load_i   (hs_load),
    .sel_hi_i (hs_sel_hi),
    .data_i   (hs_data),
    .ack_i    (wr_ack),
    .wr_lo_o  (wr_lo),
    .wr_hi_o  (wr_hi),
    .wr_data_o(wr_data),
    .fire_o   (wr_fire)
  );

  // Sequencer FSM with registered status and ALU-input outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      alu_select <= 4'b0000;
      alu_a      <= '0;
      alu_b      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            alu_select <= op;
            alu_a      <= a_in;
            alu_b      <= b_in;
            busy       <= 1'b1;
            err        <= 1'b0;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (is_illegal(alu_select) || ((alu_select == OP_DIV) && (alu_b == '0))) begin
            err     <= 1'b1;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q   <= SettleInit;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          hi_q    <= alu_z[2*WIDTH-1:WIDTH];
          state_q <= StWriteLo;
        end
        StWriteLo: begin
          if (wr_fire) begin
            if (is_two_result(alu_select)) begin
              state_q <= StWriteHi;
            end else begin
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StWriteHi: begin
          if (wr_fire) begin
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-level model compared every cycle plus literal scenarios.
module tb_alu_op_sequencer;

  localparam int unsigned S = 4;
  localparam int unsigned W = 32;

  logic           clock = 1'b0;
  logic           clear = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     op    = '0;
  logic [W-1:0]   a_in  = '0;
  logic [W-1:0]   b_in  = '0;
  logic           busy, done, err;
  logic [3:0]     alu_select;
  logic [W-1:0]   alu_a, alu_b;
  logic [2*W-1:0] alu_z = '0;
  logic           wr_lo, wr_hi;
  logic [W-1:0]   wr_data;
  logic           wr_ack = 1'b0;

  alu_op_sequencer #(
    .SETTLE_CYCLES(S),
    .WIDTH        (W)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .alu_select(alu_select),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_z     (alu_z),
    .wr_lo     (wr_lo),
    .wr_hi     (wr_hi),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ack_delay = 0;  // <0: random ack, else ack after this many write cycles

  // Transaction model: waiting, pre-write countdown, draining a write list, done.
  typedef enum int {PIdle, PPre, PWrite, PDone} phase_e;
  phase_e       ph     = PIdle;
  int           m_pre  = 0;
  int           m_wcyc = 0;
  logic         m_err  = 1'b0;
  logic [3:0]   m_sel  = '0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;
  logic [W-1:0] m_last = '0;
  logic [W:0]   wq[$];  // {is_hi, data}

  function automatic bit illegal_op(input logic [3:0] o);
    return (o == 4'h0) || (o == 4'h4) || (o == 4'h9);
  endfunction

  function automatic bit two_result_op(input logic [3:0] o);
    return (o == 4'h3) || (o == 4'h5);
  endfunction

  function automatic logic [2*W-1:0] alu_fn(input logic [3:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    case (o)
      4'h1:    return {{W{1'b0}}, x + y};
      4'h2:    return {{W{1'b0}}, x - y};
      4'h3:    return 64'(x) * 64'(y);
      4'h5:    return (y == '0) ? '0 : {x % y, x / y};
      default: return {x ^ y, ~x};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (!clear) begin
      ph = PIdle; m_sel = '0; m_a = '0; m_b = '0; m_err = 1'b0; m_last = '0;
      wq.delete();
    end else begin
      case (ph)
        PIdle: if (start) begin
          m_sel = op; m_a = a_in; m_b = b_in;
          m_err = illegal_op(op) || ((op == 4'h5) && (b_in == '0));
          m_pre = m_err ? 1 : S + 2;
          ph    = PPre;
        end
        PPre: begin
          if (m_pre == 1 && !m_err) begin
            wq.push_back({1'b0, alu_z[W-1:0]});
            if (two_result_op(m_sel)) wq.push_back({1'b1, alu_z[2*W-1:W]});
          end
          m_pre--;
          m_wcyc = 0;
          if (m_pre == 0) ph = m_err ? PDone : PWrite;
        end
        PWrite: begin
          if (wr_ack) begin
            void'(wq.pop_front());
            m_wcyc = 0;
            if (wq.size() == 0) ph = PDone;
          end else begin
            m_wcyc++;
          end
        end
        PDone: ph = PIdle;
        default: ph = PIdle;
      endcase
    end
  end

  // Compare every cycle, then drive the ALU result and write ack for the coming edge.
  initial forever begin
    logic hd_hi;
    @(negedge clock);
    hd_hi = 1'b0;
    if (ph == PWrite) begin
      hd_hi  = wq[0][W];
      m_last = wq[0][W-1:0];
    end
    chk("busy", busy, ph != PIdle);
    chk("done", done, ph == PDone);
    if (ph == PDone) chk("err", err, m_err);
    chk("wr_lo", wr_lo, (ph == PWrite) && !hd_hi);
    chk("wr_hi", wr_hi, (ph == PWrite) && hd_hi);
    chk("wr_data", wr_data, m_last);
    chk("alu_select", alu_select, m_sel);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    // Z is only valid on the capture cycle; garbage elsewhere exposes a mistimed capture.
    if (ph == PPre && m_pre == 1 && !m_err) alu_z = alu_fn(m_sel, m_a, m_b);
    else alu_z = {$urandom, $urandom};
    if (ph == PWrite) wr_ack = (ack_delay < 0) ? 1'($urandom_range(0, 1)) : (m_wcyc >= ack_delay);
    else wr_ack = 1'($urandom_range(0, 1));
  end

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int dly, input bit poke, output int lat, output int nlo,
                        output int nhi, output logic [W-1:0] dlo, output logic [W-1:0] dhi,
                        output logic e, output int lo_cyc);
    int st;
    lat = -1; nlo = 0; nhi = 0; dlo = '0; dhi = '0; e = 1'b0; lo_cyc = 0;
    @(posedge clock); #1;
    op = o; a_in = a; b_in = b; ack_delay = dly; start = 1'b1; st = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #2;
      if (poke) start = wr_lo;  // stray request while the write is pending
      if (wr_lo) lo_cyc++;
      if (wr_lo && wr_ack) begin nlo++; dlo = wr_data; end
      if (wr_hi && wr_ack) begin nhi++; dhi = wr_data; end
      if (done) begin lat = cyc - st + 1; e = err; break; end
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, nlo, nhi, lo_cyc;
    logic [W-1:0] dlo, dhi;
    logic e;
    bit seen;

    clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); #2;
    chk("rst_flags", {busy, done, err, wr_lo, wr_hi, alu_select}, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_alu", {alu_a, alu_b}, 0);
    @(posedge clock); #1;
    clear = 1'b1;

    // add 5+7, immediate ack
    run_op(4'h1, 32'd5, 32'd7, 0, 0, lat, nlo, nhi, dlo, dhi, e, lo_cyc);
    chk("add_lat", lat, 9);
    chk("add_nlo", nlo, 1);
    chk("add_data", dlo, 12);
    chk("add_nhi", nhi, 0);
    chk("add_err", e, 0);

    // mul 0x10000*0x10000 = 1_00000000
    run_op(4'h3, 32'h10000, 32'h10000, 0, 0, lat, nlo, nhi, dlo, dhi, e, lo_cyc);
    chk("mul_lat", lat, 10);
    chk("mul_lo", {nlo, dlo}, {32'd1, 32'h0});
    chk("mul_hi", {nhi, dhi}, {32'd1, 32'h1});
    chk("mul_err", e, 0);

    // divide by zero, then illegal op
    run_op(4'h5, 32'd9, 32'd0, 0, 0, lat, nlo, nhi, dlo, dhi, e, lo_cyc);
    chk("div0_lat", lat, 3);
    chk("div0_err", e, 1);
    chk("div0_writes", nlo + nhi, 0);
    run_op(4'h4, 32'd1, 32'd2, 0, 0, lat, nlo, nhi, dlo, dhi, e, lo_cyc);
    chk("ill_lat", lat, 3);
    chk("ill_err", e, 1);
    chk("ill_writes", nlo + nhi, 0);

    // ack delayed 3 cycles with stray start pulses
    run_op(4'h1, 32'd100, 32'd23, 3, 1, lat, nlo, nhi, dlo, dhi, e, lo_cyc);
    chk("dly_lo_cycles", lo_cyc, 4);
    chk("dly_data", dlo, 123);
    chk("dly_lat", lat, 12);
    @(negedge clock); #2;
    chk("dly_no_queued_start", busy, 0);

    // reset during the HI write
    @(posedge clock); #1;
    op = 4'h3; a_in = 32'h3; b_in = 32'h5; ack_delay = 5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock); #2;
      seen = wr_hi;
    end
    chk("hi_seen", seen, 1);
    clear = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    @(negedge clock); #2;
    chk("midrst_flags", {busy, done, err, wr_lo, wr_hi, alu_select}, 0);
    chk("midrst_data", wr_data, 0);
    chk("midrst_alu", {alu_a, alu_b}, 0);
    run_op(4'h1, 32'd5, 32'd7, 0, 0, lat, nlo, nhi, dlo, dhi, e, lo_cyc);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_data", dlo, 12);

    // random traffic: ops, operands, stray starts, random acks, rare resets
    ack_delay = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom);
      a_in  = $urandom;
      b_in  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      clear = ($urandom_range(0, 249) != 0);
    end
    @(posedge clock); #1;
    start = 1'b0; clear = 1'b1; ack_delay = 0;
    repeat (30) @(posedge clock);
    @(negedge clock); #2;
    chk("drain_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
